// File: rtl/video_timing_pkg.sv
// Raster timing constants for 576p50 / 480p60 and the per-mode
// selector shared by the timing generator and the OSD overlay.
package video_timing_pkg;

    typedef struct packed {
        logic [10:0] h_act;
        logic [10:0] h_fp;
        logic [10:0] h_sync;
        logic [10:0] h_bp;
        logic [9:0]  v_act;
        logic [9:0]  v_fp;
        logic [9:0]  v_sync;
        logic [9:0]  v_bp;
    } timing_t;

    localparam logic [10:0] PAL_H_ACT  = 11'd720;
    localparam logic [10:0] PAL_H_FP   = 11'd12;
    localparam logic [10:0] PAL_H_SYNC = 11'd64;
    localparam logic [10:0] PAL_H_BP   = 11'd68;
    localparam logic [9:0]  PAL_V_ACT  = 10'd576;
    localparam logic [9:0]  PAL_V_FP   = 10'd5;
    localparam logic [9:0]  PAL_V_SYNC = 10'd5;
    localparam logic [9:0]  PAL_V_BP   = 10'd39;

    localparam logic [10:0] NTSC_H_ACT  = 11'd720;
    localparam logic [10:0] NTSC_H_FP   = 11'd16;
    localparam logic [10:0] NTSC_H_SYNC = 11'd62;
    localparam logic [10:0] NTSC_H_BP   = 11'd60;
    localparam logic [9:0]  NTSC_V_ACT  = 10'd480;
    localparam logic [9:0]  NTSC_V_FP   = 10'd9;
    localparam logic [9:0]  NTSC_V_SYNC = 10'd6;
    localparam logic [9:0]  NTSC_V_BP   = 10'd30;

    localparam logic [10:0] PAL_H_TOTAL =
        PAL_H_ACT + PAL_H_FP + PAL_H_SYNC + PAL_H_BP;
    localparam logic [9:0]  PAL_V_TOTAL =
        PAL_V_ACT + PAL_V_FP + PAL_V_SYNC + PAL_V_BP;
    localparam logic [10:0] NTSC_H_TOTAL =
        NTSC_H_ACT + NTSC_H_FP + NTSC_H_SYNC + NTSC_H_BP;
    localparam logic [9:0]  NTSC_V_TOTAL =
        NTSC_V_ACT + NTSC_V_FP + NTSC_V_SYNC + NTSC_V_BP;

    // mode 1 = 576p50, mode 0 = 480p60
    function automatic timing_t timing_sel(input logic mode);
        timing_t t;
        if (mode) begin
            t.h_act  = PAL_H_ACT;
            t.h_fp   = PAL_H_FP;
            t.h_sync = PAL_H_SYNC;
            t.h_bp   = PAL_H_BP;
            t.v_act  = PAL_V_ACT;
            t.v_fp   = PAL_V_FP;
            t.v_sync = PAL_V_SYNC;
            t.v_bp   = PAL_V_BP;
        end else begin
            t.h_act  = NTSC_H_ACT;
            t.h_fp   = NTSC_H_FP;
            t.h_sync = NTSC_H_SYNC;
            t.h_bp   = NTSC_H_BP;
            t.v_act  = NTSC_V_ACT;
            t.v_fp   = NTSC_V_FP;
            t.v_sync = NTSC_V_SYNC;
            t.v_bp   = NTSC_V_BP;
        end
        return t;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster output bundle: hs/vs/de, pixel x/y, sof, pal_active.
// master drives the raster, slave (encoder / overlay) consumes it.
interface video_timing_if;

    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof;
    logic        pal_active;

    modport master (
        output hs, vs, de, x, y, sof, pal_active
    );

    modport slave (
        input hs, vs, de, x, y, sof, pal_active
    );

endinterface

// File: rtl/video_timing_decode.sv
// Combinational raster decode of (hc, vc, mode).
// Out: hs_n/vs_n (active-low sync levels), vs_upd, de, sof, h_last, v_last.
module video_timing_decode
    import video_timing_pkg::*;
(
    input  logic [10:0] hc,
    input  logic [9:0]  vc,
    input  logic        mode,
    output logic        hs_n,
    output logic        vs_n,
    output logic        vs_upd,
    output logic        de,
    output logic        sof,
    output logic        h_last,
    output logic        v_last
);

    timing_t     tm;
    logic [10:0] hs_beg;
    logic [10:0] hs_end;
    logic [10:0] h_tot;
    logic [9:0]  vs_beg;
    logic [9:0]  vs_end;
    logic [9:0]  v_tot;

    always_comb begin
        tm     = timing_sel(mode);
        hs_beg = tm.h_act + tm.h_fp;
        hs_end = hs_beg + tm.h_sync;
        h_tot  = hs_end + tm.h_bp;
        vs_beg = tm.v_act + tm.v_fp;
        vs_end = vs_beg + tm.v_sync;
        v_tot  = vs_end + tm.v_bp;
        de     = (hc < tm.h_act) && (vc < tm.v_act);
        hs_n   = !((hc >= hs_beg) && (hc < hs_end));
        vs_n   = !((vc >= vs_beg) && (vc < vs_end));
        // vsync edges line up with the hsync leading edge
        vs_upd = (hc == hs_beg);
        sof    = (hc == 11'd0) && (vc == 10'd0);
        h_last = (hc == h_tot - 11'd1);
        v_last = (vc == v_tot - 10'd1);
    end

endmodule

// File: rtl/video_timing_gen.sv
// HDMI raster timing generator, 576p50 / 480p60, resyncable by vreset.
// In: clk, reset_n, pal, vreset. Out: vid (hs, vs, de, x, y, sof, pal_active).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter logic [10:0] RESYNC_X = 11'd1,
    parameter logic [9:0]  RESYNC_Y = 10'd0,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           pal,
    input  logic           vreset,
    video_timing_if.master vid
);

    logic [10:0] hc;
    logic [9:0]  vc;
    logic        mode;
    logic        hs_n;
    logic        vs_n;
    logic        vs_upd;
    logic        de_c;
    logic        sof_c;
    logic        h_last;
    logic        v_last;

    video_timing_decode u_dec (
        .hc     (hc),
        .vc     (vc),
        .mode   (mode),
        .hs_n   (hs_n),
        .vs_n   (vs_n),
        .vs_upd (vs_upd),
        .de     (de_c),
        .sof    (sof_c),
        .h_last (h_last),
        .v_last (v_last)
    );

    // mode only changes at a frame boundary or on resync
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hc   <= '0;
            vc   <= '0;
            mode <= pal;
        end else if (vreset) begin
            hc   <= RESYNC_X;
            vc   <= RESYNC_Y;
            mode <= pal;
        end else if (h_last) begin
            hc <= '0;
            if (v_last) begin
                vc   <= '0;
                mode <= pal;
            end else begin
                vc <= vc + 10'd1;
            end
        end else begin
            hc <= hc + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vid.hs  <= ~SYNC_POL;
            vid.vs  <= ~SYNC_POL;
            vid.de  <= 1'b0;
            vid.x   <= '0;
            vid.y   <= '0;
            vid.sof <= 1'b0;
        end else begin
            vid.hs  <= hs_n ? ~SYNC_POL : SYNC_POL;
            if (vs_upd) begin
                vid.vs <= vs_n ? ~SYNC_POL : SYNC_POL;
            end
            vid.de  <= de_c;
            vid.sof <= sof_c;
            if (de_c) begin
                vid.x <= hc;
                vid.y <= vc;
            end
        end
    end

    assign vid.pal_active = mode;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: three instances, two of them
// with resync targets near frame end so wraps are reachable quickly.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic pal;
    logic vreset_a;
    logic vreset_b;
    logic vreset_c;

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;

    video_timing_if vif_a ();
    video_timing_if vif_b ();
    video_timing_if vif_c ();

    video_timing_gen u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .pal     (pal),
        .vreset  (vreset_a),
        .vid     (vif_a)
    );

    video_timing_gen #(
        .RESYNC_X (11'd700),
        .RESYNC_Y (10'd580)
    ) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .pal     (pal),
        .vreset  (vreset_b),
        .vid     (vif_b)
    );

    video_timing_gen #(
        .RESYNC_X (11'd800),
        .RESYNC_Y (10'd523)
    ) u_c (
        .clk     (clk),
        .reset_n (reset_n),
        .pal     (pal),
        .vreset  (vreset_c),
        .vid     (vif_c)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        t += n;
    endtask

    // outputs seen after this reflect counter position p
    task automatic at(input int p);
        if (p + 1 > t) tick(p + 1 - t);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        pal      = 1'b1;
        vreset_a = 1'b1;
        vreset_b = 1'b0;
        vreset_c = 1'b0;
        tick(3);
        chk("rst_hs", vif_a.hs, 1);
        chk("rst_vs", vif_a.vs, 1);
        chk("rst_de", vif_a.de, 0);
        chk("rst_x", vif_a.x, 0);
        chk("rst_y", vif_a.y, 0);
        chk("rst_sof", vif_a.sof, 0);
        chk("rst_pal", vif_a.pal_active, 1);

        // release with vreset held at origin: idempotent
        reset_n = 1'b1;
        t = 0;
        at(0);
        vreset_a = 1'b0;
        chk("p0_de", vif_a.de, 1);
        chk("p0_sof", vif_a.sof, 1);
        chk("p0_x", vif_a.x, 0);
        chk("p0_y", vif_a.y, 0);
        at(1);
        chk("p1_x", vif_a.x, 1);
        chk("p1_sof", vif_a.sof, 0);
        at(719);
        chk("p719_de", vif_a.de, 1);
        chk("p719_x", vif_a.x, 719);
        at(720);
        chk("p720_de", vif_a.de, 0);
        chk("p720_xhold", vif_a.x, 719);
        at(731);
        chk("p731_hs", vif_a.hs, 1);
        at(732);
        chk("p732_hs", vif_a.hs, 0);
        chk("p732_vs", vif_a.vs, 1);
        at(795);
        chk("p795_hs", vif_a.hs, 0);
        at(796);
        chk("p796_hs", vif_a.hs, 1);
        at(863);
        chk("p863_de", vif_a.de, 0);
        at(864);
        chk("p864_de", vif_a.de, 1);
        chk("p864_x", vif_a.x, 0);
        chk("p864_y", vif_a.y, 1);

        // vreset at hc=400, vc=2
        at(2127);
        vreset_a = 1'b1;
        tick(1);
        vreset_a = 1'b0;
        chk("vr_pre_x", vif_a.x, 400);
        chk("vr_pre_y", vif_a.y, 2);
        tick(1);
        chk("vr_de", vif_a.de, 1);
        chk("vr_x", vif_a.x, 1);
        chk("vr_y", vif_a.y, 0);
        chk("vr_sof", vif_a.sof, 0);
        t = 2;
        at(720);
        chk("vr_l0_de", vif_a.de, 0);
        at(864);
        chk("vr_l1_x", vif_a.x, 0);
        chk("vr_l1_y", vif_a.y, 1);
        at(1595);
        chk("vr_hs_pre", vif_a.hs, 1);
        at(1596);
        chk("vr_hs_on", vif_a.hs, 0);

        // reset mid-line with vreset high, switch to 480p
        at(1800);
        chk("ml_de", vif_a.de, 1);
        reset_n  = 1'b0;
        vreset_a = 1'b1;
        pal      = 1'b0;
        tick(1);
        chk("ml_rst_de", vif_a.de, 0);
        chk("ml_rst_x", vif_a.x, 0);
        chk("ml_rst_y", vif_a.y, 0);
        chk("ml_rst_pal", vif_a.pal_active, 0);
        tick(1);
        reset_n  = 1'b1;
        vreset_a = 1'b0;
        t = 0;
        at(0);
        chk("n0_sof", vif_a.sof, 1);
        chk("n0_x", vif_a.x, 0);
        chk("n0_pal", vif_a.pal_active, 0);
        at(735);
        chk("n735_hs", vif_a.hs, 1);
        at(736);
        chk("n736_hs", vif_a.hs, 0);
        at(797);
        chk("n797_hs", vif_a.hs, 0);
        at(798);
        chk("n798_hs", vif_a.hs, 1);
        at(857);
        chk("n857_de", vif_a.de, 0);
        at(858);
        chk("n858_de", vif_a.de, 1);
        chk("n858_y", vif_a.y, 1);

        // instance b: 576p resync to (700,580), vsync and frame wrap
        pal      = 1'b1;
        vreset_b = 1'b1;
        tick(1);
        vreset_b = 1'b0;
        t = 0;
        at(164);
        chk("b_vs_l581h0", vif_b.vs, 1);
        at(895);
        chk("b_vs_pre", vif_b.vs, 1);
        at(896);
        chk("b_vs_on", vif_b.vs, 0);
        chk("b_hs_on", vif_b.hs, 0);
        at(5215);
        chk("b_vs_last", vif_b.vs, 0);
        at(5216);
        chk("b_vs_off", vif_b.vs, 1);
        pal = 1'b0;
        at(38178);
        chk("b_pal_hold", vif_b.pal_active, 1);
        chk("b_end_de", vif_b.de, 0);
        at(38179);
        chk("b_pal_wrap", vif_b.pal_active, 0);
        chk("b_end_sof", vif_b.sof, 0);
        at(38180);
        chk("b_sof", vif_b.sof, 1);
        chk("b_sof_de", vif_b.de, 1);
        chk("b_sof_y", vif_b.y, 0);
        at(38915);
        chk("b_n_hs_pre", vif_b.hs, 1);
        at(38916);
        chk("b_n_hs_on", vif_b.hs, 0);
        at(39037);
        chk("b_n_l0end", vif_b.de, 0);
        at(39038);
        chk("b_n_l1_de", vif_b.de, 1);
        chk("b_n_l1_y", vif_b.y, 1);

        // instance c: 480p resync to (800,523), vreset on frame wrap
        vreset_c = 1'b1;
        tick(1);
        vreset_c = 1'b0;
        t = 0;
        at(914);
        pal      = 1'b1;
        vreset_c = 1'b1;
        tick(1);
        vreset_c = 1'b0;
        chk("c_pal_now", vif_c.pal_active, 1);
        t = 0;
        at(0);
        chk("c_ld_sof", vif_c.sof, 0);
        chk("c_ld_de", vif_c.de, 0);
        at(63);
        chk("c_l523_end", vif_c.de, 0);
        at(64);
        chk("c_l524_de", vif_c.de, 1);
        chk("c_l524_y", vif_c.y, 524);
        at(795);
        chk("c_hs_pre", vif_c.hs, 1);
        at(796);
        chk("c_hs_on", vif_c.hs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
